issue_stage: RTL and testbench

- Decode/register-read stage directly upstream of the execute stage.
- Takes one 32-bit instruction per cycle from fetch and decodes it into execute-stage control fields.
- Reads operands from an internal 32x32 register file, which is written by the writeback port.
- Interlocks RAW/WAW hazards with a per-register pending scoreboard and squashes on taken branch.

---
 rtl/issue_stage_pkg.sv | 73 +++++++
 rtl/issue_stage_regfile_2r1w.sv | 25 ++
 rtl/issue_stage.sv | 121 ++++++++++++
 tb/tb_issue_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_pkg.sv
// rtl/issue_stage_pkg.sv - Widths, opcodes, instruction field positions and decode helpers for issue_stage
package issue_stage_pkg;

    localparam int ADDR     = 16;
    localparam int W_OPC    = 7;
    localparam int W_OPR    = 32;
    localparam int W_RD     = 5;
    localparam int W_IMM    = 16;
    localparam int NREG     = 1 << W_RD;

    localparam int OPC_LSB  = 25;
    localparam int RD_LSB   = 20;
    localparam int IMMF_BIT = 19;
    localparam int RS_LSB   = 14;
    localparam int IMM_LSB  = 0;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
        OP_CMP  = 5'd4,  OP_ABS  = 5'd5,  OP_ADC  = 5'd6,  OP_SBC  = 5'd7,
        OP_SHL  = 5'd8,  OP_SHR  = 5'd9,  OP_ASH  = 5'd10, OP_ROL  = 5'd12,
        OP_ROR  = 5'd13, OP_AND  = 5'd16, OP_OR   = 5'd17, OP_NOT  = 5'd18,
        OP_XOR  = 5'd19, OP_SETL = 5'd22, OP_SETH = 5'd23, OP_LD   = 5'd24,
        OP_ST   = 5'd25, OP_J    = 5'd28, OP_JA   = 5'd29, OP_NOP  = 5'd30,
        OP_HLT  = 5'd31
    } op_e;

    typedef struct packed {
        logic [ADDR-1:0]  pc;
        logic [W_OPC-1:0] opc;
        logic [W_OPR-1:0] opr0;
        logic [W_OPR-1:0] opr1;
        logic             immf;
        logic             immsign;
        logic             stf;
        logic             wb;
        logic [W_IMM-1:0] imm;
        logic [W_RD-1:0]  wb_r;
    } issue_fields_t;

    // Any opcode outside the map (including non-zero upper bits) is issued as a NOP.
    function automatic op_e op_norm(input logic [W_OPC-1:0] opc);
        op_e op;
        op = OP_NOP;
        if (opc[W_OPC-1:5] == '0) begin
            case (opc[4:0])
                5'd11, 5'd14, 5'd15, 5'd20, 5'd21, 5'd26, 5'd27: op = OP_NOP;
                default: op = op_e'(opc[4:0]);
            endcase
        end
        return op;
    endfunction

    function automatic logic dec_wb(input op_e op);
        return !(op inside {OP_CMP, OP_ST, OP_J, OP_JA, OP_NOP, OP_HLT});
    endfunction

    function automatic logic dec_immsign(input op_e op);
        return (op <= OP_SBC) || (op == OP_J) || (op == OP_JA);
    endfunction

    function automatic logic dec_is_jump(input op_e op);
        return (op == OP_J) || (op == OP_JA);
    endfunction

    function automatic logic dec_use_rd(input op_e op);
        return !(op inside {OP_LD, OP_J, OP_JA, OP_NOP, OP_HLT});
    endfunction

    function automatic logic dec_use_rs(input op_e op, input logic immf);
        return !immf && !(op inside {OP_NOP, OP_HLT, OP_SETL, OP_SETH});
    endfunction

endpackage

// File: rtl/issue_stage_regfile_2r1w.sv
// rtl/issue_stage_regfile_2r1w.sv - 2-read/1-write register file, async reads with write-through
module issue_stage_regfile_2r1w #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic [AW-1:0] ra0_i,
    output logic [W-1:0]  rd0_o,
    input  logic [AW-1:0] ra1_i,
    output logic [W-1:0]  rd1_o
);

    logic [W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wa_i] <= wd_i;
    end

    assign rd0_o = (we_i && (wa_i == ra0_i)) ? wd_i : mem_q[ra0_i];
    assign rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : mem_q[ra1_i];

endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - Decode/register-read stage with pending-register scoreboard interlock
// Define ISSUE_BYPASS_EN to let a source pending only on the current writeback issue that cycle.
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              v_i,
    input  logic [31:0]       inst_i,
    input  logic [ADDR-1:0]   pc_i,
    output logic              stall_o,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_r_i,
    input  logic [W_OPR-1:0]  wb_data_i,
    output logic              v_o,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_OPC-1:0]  opecode_o,
    output logic [W_OPR-1:0]  opr0_o,
    output logic [W_OPR-1:0]  opr1_o,
    output logic              immf_o,
    output logic              immsign_o,
    output logic              stf_o,
    output logic              wb_o,
    output logic [W_IMM-1:0]  imm_o,
    output logic [W_RD-1:0]   wb_r_o
);

    op_e              op;
    logic [W_RD-1:0]  rd, rs;
    logic             immf, use_rd, use_rs, writes_rd;
    logic [W_OPR-1:0] rdata0, rdata1;
    logic [NREG-1:0]  pend_q, pend_d, src_pend;
    logic             hazard, issue;
    logic             v_q, v_d;
    issue_fields_t    out_q, out_d, fields;

    assign op        = op_norm(inst_i[OPC_LSB +: W_OPC]);
    assign rd        = inst_i[RD_LSB +: W_RD];
    assign rs        = inst_i[RS_LSB +: W_RD];
    assign immf      = inst_i[IMMF_BIT];
    assign use_rd    = dec_use_rd(op);
    assign use_rs    = dec_use_rs(op, immf);
    assign writes_rd = dec_wb(op);

    issue_stage_regfile_2r1w #(.W(W_OPR), .AW(W_RD)) u_regfile (
        .clk   (clk),
        .we_i  (wb_i),
        .wa_i  (wb_r_i),
        .wd_i  (wb_data_i),
        .ra0_i (rd),
        .rd0_o (rdata0),
        .ra1_i (rs),
        .rd1_o (rdata1)
    );

`ifdef ISSUE_BYPASS_EN
    // The write-through read already returns wb_data_i, so only the interlock needs relaxing.
    assign src_pend = pend_q & ~({{(NREG-1){1'b0}}, wb_i} << wb_r_i);
`else
    assign src_pend = pend_q;
`endif

    // WAW uses the raw scoreboard in both builds.
    assign hazard  = v_i & ~branch_i &
                     ((use_rd & src_pend[rd]) | (use_rs & src_pend[rs]) | (writes_rd & pend_q[rd]));
    assign stall_o = stall_i | hazard;
    assign issue   = v_i & ~stall_i & ~branch_i & ~hazard;

    always_comb begin
        fields         = '0;
        fields.pc      = pc_i;
        fields.opc     = W_OPC'(op);
        fields.opr0    = use_rd ? rdata0 : (dec_is_jump(op) ? W_OPR'(rd) : '0);
        fields.opr1    = use_rs ? rdata1 : '0;
        fields.immf    = immf;
        fields.immsign = dec_immsign(op);
        fields.stf     = (op == OP_ST);
        fields.wb      = writes_rd;
        fields.imm     = immf ? inst_i[IMM_LSB +: W_IMM] : '0;
        fields.wb_r    = rd;
    end

    always_comb begin
        v_d    = v_q;
        out_d  = out_q;
        pend_d = pend_q;
        if (wb_i) pend_d[wb_r_i] = 1'b0;
        if (!stall_i) begin
            v_d = issue;
            if (!branch_i && !hazard) out_d = fields;
            if (issue && writes_rd) pend_d[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            out_q  <= '0;
            pend_q <= '0;
        end else begin
            v_q    <= v_d;
            out_q  <= out_d;
            pend_q <= pend_d;
        end
    end

    assign v_o       = v_q;
    assign pc_o      = out_q.pc;
    assign opecode_o = out_q.opc;
    assign opr0_o    = out_q.opr0;
    assign opr1_o    = out_q.opr1;
    assign immf_o    = out_q.immf;
    assign immsign_o = out_q.immsign;
    assign stf_o     = out_q.stf;
    assign wb_o      = out_q.wb;
    assign imm_o     = out_q.imm;
    assign wb_r_o    = out_q.wb_r;

endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - Self-checking bench for issue_stage against a rule-level reference model
module tb_issue_stage;

`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i, stall_i, branch_i, wb_i;
    logic [31:0] inst_i, wb_data_i;
    logic [15:0] pc_i;
    logic [4:0]  wb_r_i;
    logic        stall_o, v_o, immf_o, immsign_o, stf_o, wb_o;
    logic [15:0] pc_o, imm_o;
    logic [6:0]  opecode_o;
    logic [31:0] opr0_o, opr1_o;
    logic [4:0]  wb_r_o;

    issue_stage dut (
        .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
        .stall_o(stall_o), .stall_i(stall_i), .branch_i(branch_i),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
        .v_o(v_o), .pc_o(pc_o), .opecode_o(opecode_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
        .immf_o(immf_o), .immsign_o(immsign_o), .stf_o(stf_o), .wb_o(wb_o),
        .imm_o(imm_o), .wb_r_o(wb_r_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  r;
        logic [31:0] d;
    } wbe_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          pend [32];
    logic [31:0] rf [32];
    wbe_t        wbq [$];
    bit          m_stall, m_issued, m_wbdst;
    logic [4:0]  m_rd;
    logic        e_v, e_immf, e_ims, e_stf, e_wb;
    logic [15:0] e_pc, e_imm;
    logic [6:0]  e_opc;
    logic [31:0] e_o0, e_o1;
    logic [4:0]  e_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int norm(input logic [6:0] o);
        int v;
        v = int'(o);
        if (v inside {[0:10], 12, 13, [16:19], 22, 23, 24, 25, [28:31]}) return v;
        return 30;
    endfunction

    function automatic bit wr_op(input int v);
        return v inside {[0:3], [5:10], 12, 13, [16:19], 22, 23, 24};
    endfunction

    function automatic logic [31:0] rd_val(input logic [4:0] r);
        return (wb_i && wb_r_i == r) ? wb_data_i : rf[r];
    endfunction

    function automatic bit src_busy(input logic [4:0] r);
        return pend[r] && !(BYP && wb_i && wb_r_i == r);
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd, input logic immf,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return immf ? {opc, rd, 1'b1, 3'b000, imm} : {opc, rd, 1'b0, rs, 14'd0};
    endfunction

    task automatic check_outs(input bit all);
        chk("v_o", 32'(v_o), 32'(e_v));
        if (e_v || all) begin
            chk("pc_o", 32'(pc_o), 32'(e_pc));
            chk("opecode_o", 32'(opecode_o), 32'(e_opc));
            chk("opr0_o", opr0_o, e_o0);
            chk("opr1_o", opr1_o, e_o1);
            chk("immf_o", 32'(immf_o), 32'(e_immf));
            chk("immsign_o", 32'(immsign_o), 32'(e_ims));
            chk("stf_o", 32'(stf_o), 32'(e_stf));
            chk("wb_o", 32'(wb_o), 32'(e_wb));
            chk("imm_o", 32'(imm_o), 32'(e_imm));
            chk("wb_r_o", 32'(wb_r_o), 32'(e_rd));
        end
    endtask

    task automatic clear_expect();
        e_v = 0; e_pc = '0; e_opc = '0; e_o0 = '0; e_o1 = '0; e_immf = 0;
        e_ims = 0; e_stf = 0; e_wb = 0; e_imm = '0; e_rd = '0;
        for (int i = 0; i < 32; i++) pend[i] = 0;
    endtask

    // One clock: inputs already driven; check stall_o, advance model at the edge, check outputs.
    task automatic step();
        int          v;
        bit          w, ims, ur, us, haz;
        logic [4:0]  rd, rs;
        logic [31:0] o0, o1;
        v   = norm(inst_i[31:25]);
        rd  = inst_i[24:20];
        rs  = inst_i[18:14];
        w   = wr_op(v);
        ims = (v <= 7) || v == 28 || v == 29;
        ur  = !(v inside {24, 28, 29, 30, 31});
        us  = !inst_i[19] && !(v inside {22, 23, 30, 31});
        haz = v_i && !branch_i && ((ur && src_busy(rd)) || (us && src_busy(rs)) || (w && pend[rd]));
        o0  = ur ? rd_val(rd) : ((v == 28 || v == 29) ? {27'd0, rd} : 32'd0);
        o1  = us ? rd_val(rs) : 32'd0;
        #1;
        m_stall = stall_i || haz;
        chk("stall_o", 32'(stall_o), 32'(m_stall));
        @(posedge clk);
        m_issued = 0;
        if (wb_i) pend[wb_r_i] = 0;
        if (!stall_i) begin
            e_v = v_i && !branch_i && !haz;
            m_issued = e_v;
            if (e_v) begin
                e_pc = pc_i; e_opc = 7'(v); e_o0 = o0; e_o1 = o1; e_immf = inst_i[19];
                e_ims = ims; e_stf = (v == 25); e_wb = w; e_rd = rd;
                e_imm = inst_i[19] ? inst_i[15:0] : 16'd0;
                if (w) pend[rd] = 1;
            end
        end
        if (wb_i) rf[wb_r_i] = wb_data_i;
        m_wbdst = w;
        m_rd = rd;
        cyc++;
        #1;
        check_outs(0);
    endtask

    // Execute model: each issued writer writes back in the cycle after next.
    task automatic tick();
        wbe_t e;
        if (wbq.size() > 0 && wbq[0].due == cyc) begin
            wb_i = 1; wb_r_i = wbq[0].r; wb_data_i = wbq[0].d;
            wbq.delete(0);
        end else begin
            wb_i = 0; wb_r_i = 5'($urandom); wb_data_i = $urandom;
        end
        step();
        if (m_issued && m_wbdst) begin
            e.due = cyc + 1; e.r = m_rd; e.d = $urandom;
            wbq.push_back(e);
        end
    endtask

    task automatic issue_one(input logic [31:0] inst, output int stalls);
        v_i = 1; inst_i = inst; pc_i = 16'($urandom); stalls = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!m_stall) begin
                v_i = 0;
                return;
            end
            stalls++;
        end
        checks++; errors++;
        $error("FAIL issue_timeout: observed stalls %0d expected fewer than 20", stalls);
        v_i = 0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opc;
        opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 31));
        return mk(opc, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 16'($urandom));
    endfunction

    initial begin
        int st;
        reset = 0; v_i = 0; inst_i = '0; pc_i = '0; stall_i = 0; branch_i = 0;
        wb_i = 0; wb_r_i = '0; wb_data_i = '0;
        clear_expect();
        repeat (2) @(posedge clk);
        #1;
        check_outs(1);
        chk("reset_stall_o", 32'(stall_o), 32'd0);
        reset = 1;

        for (int i = 0; i < 32; i++) begin
            wb_i = 1; wb_r_i = 5'(i); wb_data_i = (i == 1) ? 32'h10 : $urandom;
            step();
        end
        wb_i = 0;

        issue_one(mk(7'd0, 5'd1, 1'b1, 5'd0, 16'h0005), st);
        chk("add_imm_v", 32'(v_o), 32'd1);
        chk("add_imm_opr0", opr0_o, 32'h10);
        chk("add_imm_immsign", 32'(immsign_o), 32'd1);
        chk("add_imm_wb", 32'(wb_o), 32'd1);
        chk("add_imm_wb_r", 32'(wb_r_o), 32'd1);

        issue_one(mk(7'd0, 5'd2, 1'b1, 5'd0, 16'h0001), st);
        issue_one(mk(7'd1, 5'd3, 1'b0, 5'd2, 16'h0000), st);
        chk("raw_stalls", 32'(st), BYP ? 32'd1 : 32'd2);
        chk("raw_opr1", opr1_o, rf[2]);

        issue_one(mk(7'd0, 5'd4, 1'b1, 5'd0, 16'h0001), st);
        issue_one(mk(7'd0, 5'd4, 1'b1, 5'd0, 16'h0002), st);
        chk("waw_stalls", 32'(st), 32'd2);
        issue_one(mk(7'd1, 5'd9, 1'b0, 5'd4, 16'h0000), st);
        chk("waw_pend_kept", 32'(st > 0), 32'd1);

        repeat (3) tick();
        branch_i = 1;
        issue_one(mk(7'd24, 5'd5, 1'b1, 5'd0, 16'h0100), st);
        branch_i = 0;
        chk("branch_drop_v", 32'(v_o), 32'd0);
        issue_one(mk(7'd0, 5'd8, 1'b0, 5'd5, 16'h0000), st);
        chk("branch_no_pend", 32'(st), 32'd0);

        issue_one(mk(7'd0, 5'd6, 1'b1, 5'd0, 16'h0007), st);
        stall_i = 1;
        repeat (3) begin
            tick();
            chk("freeze_stall_o", 32'(stall_o), 32'd1);
            chk("freeze_wb_r", 32'(wb_r_o), 32'd6);
        end
        stall_i = 0;
        issue_one(mk(7'd16, 5'd10, 1'b0, 5'd6, 16'h0000), st);
        chk("freeze_r6_cleared", 32'(st), 32'd0);

        issue_one(mk(7'd0, 5'd3, 1'b1, 5'd0, 16'h0001), st);
        issue_one(mk(7'd29, 5'd3, 1'b1, 5'd0, 16'h0040), st);
        chk("ja_stalls", 32'(st), 32'd0);
        chk("ja_opr0", opr0_o, 32'h3);
        chk("ja_imm", 32'(imm_o), 32'h40);
        chk("ja_wb", 32'(wb_o), 32'd0);

        m_stall = 0;
        for (int n = 0; n < 400; n++) begin
            if (!m_stall) begin
                v_i = ($urandom_range(0, 4) != 0);
                inst_i = rand_inst();
                pc_i = 16'($urandom);
            end
            stall_i = ($urandom_range(0, 6) == 0);
            branch_i = !stall_i && ($urandom_range(0, 9) == 0);
            tick();
        end
        v_i = 0; stall_i = 0; branch_i = 0;
        repeat (4) tick();

        issue_one(mk(7'd0, 5'd7, 1'b1, 5'd0, 16'h0003), st);
        wb_i = 0;
        reset = 0;
        #1;
        clear_expect();
        wbq.delete();
        check_outs(1);
        @(posedge clk);
        #1;
        reset = 1;
        issue_one(mk(7'd0, 5'd11, 1'b0, 5'd7, 16'h0000), st);
        chk("reset_clears_pend", 32'(st), 32'd0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
